// File: rtl/me_sched_pkg.sv
// me_sched_pkg: opcodes, FSM state encoding and default widths shared by
// the me_sched job scheduler and its round-robin arbiter.
package me_sched_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int TAG_W_DEF = 4;

  localparam logic [1:0] OP_ME     = 2'd0;
  localparam logic [1:0] OP_PRE_ME = 2'd1;
  localparam logic [1:0] OP_ONE_MM = 2'd2;
  localparam logic [1:0] OP_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/me_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Searches upward from ptr,
// wrapping modulo NREQ; returns a one-hot grant, the winner index and a
// flag telling whether anyone requested at all.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int SEL_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [SEL_W-1:0] cand;

  // First requester found at or after ptr wins
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = SEL_W'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/me_sched.sv
// me_sched: round-robin scheduler sharing one modular-exponentiation engine
// among NREQ requesters. Accepts one job at a time, pulses the matching
// engine enable, holds the operand-mux select for the whole job, checks the
// returned tag and hands the result back over a valid/ready response port.
// Optional: define ME_SCHED_PERF_EN to add perf_busy / perf_jobs counters.
module me_sched
  import me_sched_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int TAG_W = TAG_W_DEF,
  parameter int SEL_W = $clog2(NREQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][1:0]        req_op,
  input  logic [NREQ-1:0][TAG_W-1:0]  req_tag,
  output logic [NREQ-1:0]             req_ready,
  output logic                        en_me,
  output logic                        en_pre_me,
  output logic                        en_one_mm,
  output logic [TAG_W-1:0]            num,
  output logic [SEL_W-1:0]            sel,
  input  logic                        done,
  input  logic [TAG_W-1:0]            num_out,
  output logic                        rsp_valid,
  output logic [SEL_W-1:0]            rsp_id,
  output logic [TAG_W-1:0]            rsp_tag,
  output logic                        rsp_err,
  input  logic                        rsp_ready
`ifdef ME_SCHED_PERF_EN
  ,
  output logic [31:0]                 perf_busy,
  output logic [15:0]                 perf_jobs
`endif
);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [NREQ-1:0]  gnt;
  logic [SEL_W-1:0] idx;
  logic             any;
  logic [1:0]       op_w;
  logic [TAG_W-1:0] tag_w;
  logic [SEL_W-1:0] ptr_nxt;

  rr_arbiter #(.NREQ(NREQ), .SEL_W(SEL_W)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx),
    .any (any)
  );

  assign op_w    = req_op[idx];
  assign tag_w   = req_tag[idx];
  assign ptr_nxt = (idx == SEL_W'(NREQ - 1)) ? '0 : idx + SEL_W'(1);

  // Acceptance strobe only in IDLE; masked by rst_n so no grant leaks while
  // the block is held in reset.
  assign req_ready = (state == S_IDLE && rst_n) ? gnt : '0;

  // Job FSM: grant -> issue pulse -> wait for engine -> hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      sel       <= '0;
      num       <= '0;
      en_me     <= 1'b0;
      en_pre_me <= 1'b0;
      en_one_mm <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else begin
      en_me     <= 1'b0;
      en_pre_me <= 1'b0;
      en_one_mm <= 1'b0;
      case (state)
        S_IDLE: if (any) begin
          sel     <= idx;
          num     <= tag_w;
          rsp_id  <= idx;
          rsp_tag <= tag_w;
          ptr     <= ptr_nxt;
          if (op_w == OP_RSVD) begin
            // reserved opcode never reaches the engine
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            // enable is registered here so it is high exactly in ISSUE
            rsp_err   <= 1'b0;
            en_me     <= (op_w == OP_ME);
            en_pre_me <= (op_w == OP_PRE_ME);
            en_one_mm <= (op_w == OP_ONE_MM);
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: if (done) begin
          rsp_err   <= (num_out != num);
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ME_SCHED_PERF_EN
  // Busy-cycle counter (saturating) and completed-job counter (wrapping)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_busy <= '0;
      perf_jobs <= '0;
    end else begin
      if ((state == S_ISSUE || state == S_WAIT) && perf_busy != '1)
        perf_busy <= perf_busy + 32'd1;
      if (rsp_valid && rsp_ready)
        perf_jobs <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_me_sched.sv
// tb_me_sched: directed bench for me_sched with a fixed-latency engine model.
module tb_me_sched;

  localparam int NREQ  = 4;
  localparam int TAG_W = 4;
  localparam int SEL_W = 2;
  localparam int LAT   = 20;

  logic                       clk = 1'b0;
  logic                       rst_n;
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0][1:0]       req_op;
  logic [NREQ-1:0][TAG_W-1:0] req_tag;
  logic [NREQ-1:0]            req_ready;
  logic                       en_me, en_pre_me, en_one_mm;
  logic [TAG_W-1:0]           num;
  logic [SEL_W-1:0]           sel;
  logic                       done;
  logic [TAG_W-1:0]           num_out;
  logic                       rsp_valid;
  logic [SEL_W-1:0]           rsp_id;
  logic [TAG_W-1:0]           rsp_tag;
  logic                       rsp_err;
  logic                       rsp_ready;
`ifdef ME_SCHED_PERF_EN
  logic [31:0]                perf_busy;
  logic [15:0]                perf_jobs;
`endif

  int checks = 0;
  int errors = 0;

  logic             bad   = 1'b0;
  logic             stray = 1'b0;
  logic             m_busy, m_done;
  logic [7:0]       m_cnt;
  logic [TAG_W-1:0] m_tag, m_num;

  always #5 clk = ~clk;

  me_sched #(.NREQ(NREQ), .TAG_W(TAG_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_tag   (req_tag),
    .req_ready (req_ready),
    .en_me     (en_me),
    .en_pre_me (en_pre_me),
    .en_one_mm (en_one_mm),
    .num       (num),
    .sel       (sel),
    .done      (done),
    .num_out   (num_out),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_tag   (rsp_tag),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
`ifdef ME_SCHED_PERF_EN
    ,
    .perf_busy (perf_busy),
    .perf_jobs (perf_jobs)
`endif
  );

  // Engine model: done LAT cycles after the enable cycle; 'bad' corrupts tag
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_cnt <= '0; m_tag <= '0; m_num <= '0;
    end else begin
      m_done <= 1'b0;
      if (en_me | en_pre_me | en_one_mm) begin
        m_busy <= 1'b1;
        m_cnt  <= 8'(LAT - 2);
        m_tag  <= num;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_num  <= m_tag ^ {3'b000, bad};
        end else begin
          m_cnt <= m_cnt - 8'd1;
        end
      end
    end
  end

  assign done    = m_done | stray;
  assign num_out = stray ? 4'hF : m_num;

  task automatic check(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  // Runs one job from an IDLE negedge through its response handshake.
  task automatic do_job(input int id, input logic [3:0] tg, input logic [2:0] en_exp,
                        input logic err_exp, input int stall);
    int n;
    #1 check("req_ready_grant", 32'(req_ready), 32'(1 << id));
    @(negedge clk);
    check("enables", 32'({en_me, en_pre_me, en_one_mm}), 32'(en_exp));
    check("sel", 32'(sel), 32'(id));
    check("num", 32'(num), 32'(tg));
    check("req_ready_busy", 32'(req_ready), 32'd0);
    if (en_exp == 3'b000) begin
      check("rsvd_rsp_next_cycle", 32'(rsp_valid), 32'd1);
    end else begin
      @(negedge clk);
      check("enable_one_cycle", 32'({en_me, en_pre_me, en_one_mm}), 32'd0);
    end
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_fields", 32'({rsp_id, rsp_tag, rsp_err}), 32'({2'(id), tg, err_exp}));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      stray = (i == 4);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_fields", 32'({rsp_id, rsp_tag, rsp_err}), 32'({2'(id), tg, err_exp}));
      check("stall_req_ready", 32'(req_ready), 32'd0);
    end
    stray = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    req_op    = '0;
    req_tag   = {4'd8, 4'd7, 4'd6, 4'd5};

    // reset: every output low even with all requests pending
    @(negedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_outputs", 32'({en_me, en_pre_me, en_one_mm, num, sel, rsp_valid,
                                rsp_id, rsp_tag, rsp_err}), 32'd0);
    rst_n = 1'b1;

    // round robin over four held requesters
    do_job(0, 4'd5, 3'b100, 1'b0, 0);
    do_job(1, 4'd6, 3'b100, 1'b0, 0);
    do_job(2, 4'd7, 3'b100, 1'b0, 0);
    do_job(3, 4'd8, 3'b100, 1'b0, 0);
    do_job(0, 4'd5, 3'b100, 1'b0, 0);

    // reserved opcode from requester 2: immediate error response, no engine
    req_valid  = 4'b0100;
    req_op[2]  = 2'd3;
    req_tag[2] = 4'd9;
    do_job(2, 4'd9, 3'b000, 1'b1, 0);

    // tag mismatch: engine returns 4 for issued 5
    req_valid = 4'b0001;
    bad       = 1'b1;
    do_job(0, 4'd5, 3'b100, 1'b1, 0);
    bad       = 1'b0;

    // response back-pressure for 10 cycles with a stray done in the middle
    req_valid  = 4'b0010;
    req_op[1]  = 2'd1;
    req_tag[1] = 4'd3;
    do_job(1, 4'd3, 3'b010, 1'b0, 10);
    req_op[1]  = 2'd2;
    req_tag[1] = 4'hA;
    do_job(1, 4'hA, 3'b001, 1'b0, 0);

    // fresh reset, one timed job, then reset in the middle of WAIT
    req_valid = 4'b0000;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 4'b0001;
    req_op[0] = 2'd0;
    do_job(0, 4'd5, 3'b100, 1'b0, 0);
`ifdef ME_SCHED_PERF_EN
    check("perf_busy", perf_busy, 32'd21);
    check("perf_jobs", 32'(perf_jobs), 32'd1);
`endif
    repeat (5) @(negedge clk);
    check("midwait_no_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    check("midwait_reset_outputs", 32'({req_ready, en_me, en_pre_me, en_one_mm, rsp_valid, sel, num}), 32'd0);
`ifdef ME_SCHED_PERF_EN
    check("perf_busy_reset", perf_busy, 32'd0);
    check("perf_jobs_reset", 32'(perf_jobs), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("idle_after_reset", 32'(req_ready), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/me_sched.md
# me_sched

Round-robin job scheduler that shares one `me_top` modular-exponentiation engine among `NREQ` requesters. It accepts one job at a time from requesters using a valid/ready handshake and drives the engine's one-cycle enable pulse and 4-bit job tag (`num`). It steers the external operand mux for the whole job, matches the returned `num_out` against the issued tag, and returns each result through a valid/ready response port.

## Interface
- `NREQ`, 4: number of requesters (2..8).
- `TAG_W`, 4: tag width; equals the engine's `num` / `num_out` width.
- `SEL_W`, `$clog2(NREQ)`: width of the grant index.
- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NREQ`: per-requester job request.
- `req_op` in `2*NREQ`: per-requester opcode. 0 = ME, 1 = PRE_ME, 2 = ONE_MM, 3 = reserved.
- `req_tag` in `TAG_W*NREQ`: per-requester job tag.
- `req_ready` out `NREQ`: one-hot acceptance strobe.
- `en_me`, `en_pre_me`, `en_one_mm` out 1 each: engine start pulses.
- `num` out `TAG_W`: tag presented to the engine.
- `sel` out `SEL_W`: operand-mux select, stable for the whole job.
- `done` in 1: engine completion pulse.
- `num_out` in `TAG_W`: tag returned by the engine.
- `rsp_valid` out 1: response available.
- `rsp_id` out `SEL_W`: index of the requester that owns the response.
- `rsp_tag` out `TAG_W`: the job's tag.
- `rsp_err` out 1: set for a reserved opcode or a tag mismatch.
- `rsp_ready` in 1: response consumed.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Arbitration is round-robin, searching upward from pointer `ptr` and wrapping modulo `NREQ`.
  - The winner's `req_ready` is asserted combinationally in the same cycle.
  - On that edge the block registers `sel`, `num`, the opcode and the tag.
  - Next state: ISSUE. If the opcode is reserved, next state is RESP with `rsp_err` = 1 and the engine is never started.
  - `ptr` becomes winner+1 (mod `NREQ`).
- ISSUE: assert exactly one enable pulse for one cycle, selected by the opcode. Next state: WAIT.
- WAIT:
  - Hold `sel` and `num`.
  - On `done`: capture `rsp_err` = (`num_out` != `num`). Next state: RESP.
- RESP:
  - `rsp_valid` = 1. `rsp_id`, `rsp_tag` and `rsp_err` are stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, next state is IDLE.
- `req_ready` is 0 in every state except IDLE. Requesters hold `req_valid`, `req_op` and `req_tag` until they are accepted.
- A `done` pulse outside WAIT is ignored and does not change any response field.
- A requester that drops `req_valid` before it is granted is simply skipped.
- Reset value of all outputs: 0. After reset, state = IDLE and `ptr` = 0.
- Reset mid-job aborts the job immediately. The engine shares `rst_n`.

## Timing
- Grant in cycle T → `sel` and `num` valid from T+1 → enable pulse in cycle T+1.
- `done` in cycle D → `rsp_valid` from D+1.
- Handshake in cycle R → IDLE at R+1, so the next grant is possible in R+1.
- Minimum gap between two engine starts: 3 cycles plus the engine latency.
- A reserved opcode granted at T gives `rsp_valid` from T+1.
- Request or response handshakes and a `done` pulse never coincide, because the FSM serialises them.

## Configuration
- `ME_SCHED_PERF_EN` defined: adds two output ports.
  - `perf_busy`, 32 bits: counts cycles in ISSUE or WAIT and saturates at all-ones.
  - `perf_jobs`, 16 bits: counts completed response handshakes and wraps.
  - Both counters reset to 0.
- `ME_SCHED_PERF_EN` undefined: these ports and counters do not exist. Behaviour is otherwise identical.

## Structure
- `me_sched_pkg` holds:
  - opcode constants `OP_ME`, `OP_PRE_ME`, `OP_ONE_MM`, `OP_RSVD`;
  - the state enum;
  - the default widths.
- Sub-module `rr_arbiter`, purely combinational:
  - inputs: request vector and `ptr`;
  - outputs: one-hot grant and the winner index.
- The operand mux (3072-bit `a`, `e`, `m`, `m_n`, `m_prime`) sits outside this block and is driven by `sel`.

## Test plan
- Reset with `req_valid` = 4'b1111 → all outputs 0. Release → `req_ready` = 4'b0001, `en_me` pulses in the next cycle, `sel` = 0.
- All four requesters hold op 0 with tags 5, 6, 7, 8; an engine model returns `done` after 20 cycles with `num_out` = `num` → grant order 0, 1, 2, 3, 0. Responses return (`rsp_id`, `rsp_tag`) = (0,5), (1,6), (2,7), (3,8), all with `rsp_err` = 0.
- Requester 2 sends op 3 with tag 9 → no enable pulse. Response (2, 9) with `rsp_err` = 1 appears one cycle after the grant.
- Engine returns `num_out` = 4 for issued tag 5 → `rsp_err` = 1, `rsp_tag` = 5.
- `rsp_ready` held 0 for 10 cycles with `req_valid` = 4'b0010 → `rsp_valid` and the response fields stay stable, and `req_ready` stays 0. Releasing `rsp_ready` gives a grant in the next cycle. A stray `done` injected during RESP changes nothing.
- With `ME_SCHED_PERF_EN`: a job with 20-cycle engine latency followed by its response → `perf_busy` = 21, `perf_jobs` = 1. Asserting `rst_n` low mid-WAIT clears both counters and the FSM returns to IDLE.
